// File: rtl/pixel_write_fifo_if.sv
// ---------------------------------------------------------------------------
// pixel_write_fifo_if
//
// Purpose: groups the pixel-source side and the framebuffer side of the
// pixel write FIFO into one bundle. Signal names follow the display-stage
// and framebuffer naming used by the surrounding system.
//
// Handshake semantics:
//   - Pixel side: plot is a single-cycle valid strobe with no ready. Every
//     edge with plot=1 offers exactly one pixel. The pixel is either stored
//     or dropped, and any drop is reported through the sticky overflow or
//     clipped flag.
//   - Framebuffer side: mem_ready=1 means the framebuffer takes a write at
//     the next edge. Each mem_we=1 cycle carries exactly one pixel on
//     mem_addr and mem_data.
//
// Signals:
//   VGA_X, VGA_Y, VGA_COLOR  pixel column, row and colour from the display stage
//   plot                     pixel-valid strobe
//   flush                    synchronous FIFO clear
//   mem_ready                framebuffer can accept a write
//   mem_addr, mem_data       registered framebuffer address and colour
//   mem_we                   registered write strobe, one cycle per pixel
//   fill                     current FIFO occupancy
//   overflow, clipped        sticky drop flags
//
// Modports:
//   slave   the FIFO itself
//   master  whatever drives pixels in and observes the framebuffer side
// ---------------------------------------------------------------------------
interface pixel_write_fifo_if;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [2:0]  VGA_COLOR;
  logic        plot;
  logic        flush;
  logic        mem_ready;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic [6:0]  fill;
  logic        overflow;
  logic        clipped;

  modport slave (
    input  VGA_X, VGA_Y, VGA_COLOR, plot, flush, mem_ready,
    output mem_addr, mem_data, mem_we, fill, overflow, clipped
  );

  modport master (
    output VGA_X, VGA_Y, VGA_COLOR, plot, flush, mem_ready,
    input  mem_addr, mem_data, mem_we, fill, overflow, clipped
  );
endinterface

// File: rtl/pixel_write_fifo.sv
// ---------------------------------------------------------------------------
// pixel_write_fifo
//
// Purpose: decouples a pixel producer from a framebuffer write port that can
// stall. On-screen pixels are queued in order. They are drained at most one
// per cycle, converted to a linear framebuffer address y*SCR_W + x, and
// presented on registered write outputs.
//
// Behaviour summary:
//   - Off-screen pixels are dropped and set the sticky clipped flag.
//   - In-range pixels that arrive while the FIFO is full are dropped and set
//     the sticky overflow flag. A full FIFO still has space when a pop happens
//     on the same edge.
//   - flush empties the FIFO, clears both flags, suppresses the write strobe
//     and ignores plot for that cycle.
//   - There is no bypass path. A pixel is stored at one edge and can leave
//     the FIFO no earlier than the following edge.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, 2..64)
//   SCR_W  screen width in pixels
//   SCR_H  screen height in pixels
//
// Ports:
//   CLOCK_50  system clock; all state changes on its rising edge
//   resetn    asynchronous active-low reset
//   bus       pixel and framebuffer signals (slave side of pixel_write_fifo_if)
// ---------------------------------------------------------------------------
module pixel_write_fifo #(
  parameter int DEPTH = 8,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  pixel_write_fifo_if.slave bus
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [6:0]  DEPTH_L = 7'(DEPTH);
  localparam int unsigned SCR_W_U = SCR_W;
  localparam int unsigned SCR_H_U = SCR_H;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
  } pixel_t;

  // Storage and pointers
  pixel_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]    fill_q, fill_d;

  // Output registers and sticky flags
  logic [14:0]   mem_addr_q, mem_addr_d;
  logic [2:0]    mem_data_q, mem_data_d;
  logic          mem_we_q, mem_we_d;
  logic          overflow_q, overflow_d;
  logic          clipped_q, clipped_d;

  // Per-cycle decisions
  logic          in_range;
  logic          pop;
  logic          space;
  logic          push;
  logic          clip_set;
  logic          ovf_set;
  pixel_t        in_px;
  pixel_t        head_px;
  logic [14:0]   head_addr;

  assign in_px = '{x: bus.VGA_X, y: bus.VGA_Y, color: bus.VGA_COLOR};

  // Zero-extend before comparing so that coordinates at or beyond the
  // screen edge are detected for any SCR_W/SCR_H.
  assign in_range = (32'(bus.VGA_X) < SCR_W_U) && (32'(bus.VGA_Y) < SCR_H_U);

  // The pop decision is made first because a pop frees a slot for a push on
  // the same edge. This lets a full FIFO keep streaming at one pixel per
  // cycle.
  assign pop      = !bus.flush && (fill_q != 7'd0) && bus.mem_ready;
  assign space    = (fill_q < DEPTH_L) || pop;
  assign push     = bus.plot && !bus.flush && in_range && space;
  assign clip_set = bus.plot && !bus.flush && !in_range;
  assign ovf_set  = bus.plot && !bus.flush && in_range && !space;

  // Linear framebuffer address of the head entry. The multiply is 15 bits
  // wide, which holds the full range y*SCR_W + x for the screen sizes this
  // block is used with.
  assign head_px   = mem_q[rd_ptr_q];
  assign head_addr = 15'(head_px.y) * 15'(SCR_W) + 15'(head_px.x);

  // Next-state logic
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    overflow_d = overflow_q | ovf_set;
    clipped_d  = clipped_q | clip_set;

    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = 7'd0;
      overflow_d = 1'b0;
      clipped_d  = 1'b0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        mem_addr_d = head_addr;
        mem_data_d = head_px.color;
        mem_we_d   = 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fill_d = fill_q + 7'd1;
        2'b01:   fill_d = fill_q - 7'd1;
        default: fill_d = fill_q;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= 7'd0;
      mem_addr_q <= 15'd0;
      mem_data_q <= 3'd0;
      mem_we_q   <= 1'b0;
      overflow_q <= 1'b0;
      clipped_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      overflow_q <= overflow_d;
      clipped_q  <= clipped_d;
    end
  end

  // The storage array has no reset. Its contents are only read when fill_q
  // shows them to be valid, so stale data is never written out.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_px;
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.fill     = fill_q;
  assign bus.overflow = overflow_q;
  assign bus.clipped  = clipped_q;

endmodule

// File: doc/pixel_write_fifo.md
PIXEL_WRITE_FIFO -- requirements
Module: pixel_write_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving FIFO entries (power of two, 2..64).
REQ-002 The block SHALL have parameter SCR_W, default 160, giving the screen width in pixels.
REQ-003 The block SHALL have parameter SCR_H, default 120, giving the screen height in pixels.
REQ-004 CLOCK_50  input  1  single system clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 VGA_X  input  8  pixel column from the display stage.
REQ-007 VGA_Y  input  7  pixel row from the display stage.
REQ-008 VGA_COLOR  input  3  pixel colour from the display stage.
REQ-009 plot  input  1  pixel-valid strobe; one pixel offered per high cycle.
REQ-010 flush  input  1  synchronous FIFO clear.
REQ-011 mem_ready  input  1  framebuffer accepts a write at the next edge.
REQ-012 mem_addr  output  15  framebuffer address, registered.
REQ-013 mem_data  output  3  framebuffer colour, registered.
REQ-014 mem_we  output  1  framebuffer write strobe, registered, one cycle per pixel.
REQ-015 fill  output  7  current FIFO occupancy, 0..DEPTH.
REQ-016 overflow  output  1  sticky: a valid pixel was dropped because the FIFO was full.
REQ-017 clipped  output  1  sticky: a pixel was dropped because it was off-screen.

Function
REQ-018 Push: at an edge with plot=1, VGA_X<SCR_W, VGA_Y<SCR_H, flush=0 and space available, the block SHALL store {x,y,colour} at the tail.
REQ-019 Space available SHALL mean fill<DEPTH, or fill==DEPTH with a pop at the same edge.
REQ-020 plot=1 with VGA_X>=SCR_W or VGA_Y>=SCR_H SHALL not push and SHALL set clipped.
REQ-021 An in-range plot=1 with no space SHALL not push and SHALL set overflow; stored entries SHALL be unaffected.
REQ-022 Pop: at an edge with fill>0, mem_ready=1 and flush=0, the block SHALL remove the head and load it into the output registers with mem_we=1.
REQ-023 At any edge without a pop, mem_we SHALL be 0; mem_addr and mem_data SHALL hold their last values.
REQ-024 mem_addr SHALL equal y*SCR_W + x; for defaults, (y<<7)+(y<<5)+x, maximum 19199, computed without truncation.
REQ-025 Order SHALL be strict FIFO; the pop rate SHALL be at most one pixel per cycle.
REQ-026 Latency: a pixel pushed at edge N into an empty FIFO SHALL appear with mem_we=1 after edge N+1 at the earliest. No bypass is allowed.
REQ-027 Simultaneous push and pop SHALL leave fill unchanged, including when fill==DEPTH or fill==1.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 flush=1 SHALL set fill to 0, discard all entries, force mem_we=0 and ignore plot that cycle.
REQ-030 flush SHALL clear overflow and clipped.
REQ-031 The sticky flags SHALL clear only on reset or flush.
REQ-032 fill SHALL be a registered count consistent with the pointers every cycle.

Reset
REQ-033 resetn=0 SHALL immediately, without waiting for a clock edge, force fill=0, mem_we=0, mem_addr=0, mem_data=0, overflow=0, clipped=0 and both pointers to 0.
REQ-034 Reset mid-stream SHALL discard queued pixels; after release, no write SHALL issue until a new push.
REQ-035 The first edge after resetn rises SHALL be treated as a normal cycle.

Verification
REQ-036 Single pixel: drive x=5, y=3, colour=3'b100, plot=1 for one cycle with mem_ready=1 -> exactly one mem_we pulse with mem_addr=485, mem_data=4, one cycle after the push.
REQ-037 Back-pressure and overflow: hold mem_ready=0, push 9 in-range pixels -> fill=8, overflow=1; then set mem_ready=1 -> 8 writes in push order on consecutive cycles, fill returns to 0.
REQ-038 Clipping: push x=160,y=0 and x=0,y=120, then x=159,y=119 -> clipped=1; exactly one write occurs, with mem_addr=19199.
REQ-039 Full with simultaneous push and pop: with fill=8 and mem_ready=1, push every cycle for 20 cycles -> fill stays 8, overflow stays 0, no pixel is lost or reordered.
REQ-040 Flush and reset: with fill=5, pulse flush -> fill=0, flags=0, no mem_we. Refill to 3, then assert resetn=0 between edges -> outputs go to 0 immediately, and no write occurs after release.
